// File: rtl/el_pkg.sv
// Shared definitions for the dual-rail receive path: rail pair encodings
// and the handshake FSM state encoding.
package el_pkg;

    localparam logic [1:0] SPACER  = 2'b00;
    localparam logic [1:0] D0      = 2'b01;
    localparam logic [1:0] D1      = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        WAIT_DATA   = 2'd0,
        WAIT_SPACER = 2'd1,
        ERROR       = 2'd2
    } state_t;

endpackage

// File: rtl/el_rx_fifo.sv
// Clocked output buffer between the dual-rail receiver and the ready/valid
// consumer; push and pop on the same edge are allowed even when full.
module el_rx_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/el_rx_sync.sv
// Dual-rail 4-phase receiver: synchronizes the rails, detects complete and
// spacer words, acknowledges the producer and buffers words for the consumer.
// Optional Fibonacci sequence checker enabled by defining EL_RX_FIB_CHECK_EN.
module el_rx_sync
    import el_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RAIL_NUM   = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RAIL_NUM*WIDTH-1:0] in,
    output logic                      ack_o,
    output logic [WIDTH-1:0]          data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      err_o
);

    localparam int RW = RAIL_NUM * WIDTH;

    function automatic logic all_complete(input logic [RW-1:0] r);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (r[2*i +: 2] != D0 && r[2*i +: 2] != D1) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic any_illegal(input logic [RW-1:0] r);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r[2*i +: 2] == ILLEGAL) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [WIDTH-1:0] decode(input logic [RW-1:0] r);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) w[i] = r[2*i+1];
        return w;
    endfunction

    logic [RW-1:0]    s1, s2, s3;
    state_t           state, nxt_state;
    logic             nxt_ack;
    logic             push, set_err, fib_bad;
    logic             stable, spacer, illegal;
    logic             full, empty, pop;
    logic [WIDTH-1:0] word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Decisions look at the s2/s3 pair this edge produces (s1 -> s2, s2 -> s3),
    // so ack and the push land on the same edge the word becomes stable.
    assign stable  = all_complete(s1) && (s1 == s2);
    assign spacer  = (s1 == '0);
    assign illegal = any_illegal(s2) || any_illegal(s3);
    assign word    = decode(s1);
    assign pop     = valid_o && ready_i;

    always_comb begin
        nxt_state = state;
        nxt_ack   = ack_o;
        push      = 1'b0;
        set_err   = 1'b0;
        if (illegal) begin
            set_err   = 1'b1;
            nxt_state = ERROR;
        end else begin
            case (state)
                WAIT_DATA: begin
                    if (stable && (!full || pop)) begin
                        push      = 1'b1;
                        nxt_ack   = 1'b1;
                        nxt_state = WAIT_SPACER;
                    end
                end
                WAIT_SPACER: begin
                    if (spacer) begin
                        nxt_ack   = 1'b0;
                        nxt_state = WAIT_DATA;
                    end
                end
                default: nxt_state = ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_DATA;
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= nxt_state;
            ack_o <= nxt_ack;
            if (set_err || fib_bad) err_o <= 1'b1;
        end
    end

`ifdef EL_RX_FIB_CHECK_EN
    logic [WIDTH-1:0] fib_w1, fib_w2, fib_sum;
    logic [1:0]       fib_cnt;

    assign fib_sum = fib_w1 + fib_w2;
    assign fib_bad = push && (fib_cnt == 2'd2) && (word != fib_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fib_w1  <= '0;
            fib_w2  <= '0;
            fib_cnt <= '0;
        end else if (push) begin
            fib_w2 <= fib_w1;
            fib_w1 <= word;
            if (fib_cnt != 2'd2) fib_cnt <= fib_cnt + 2'd1;
        end
    end
`else
    assign fib_bad = 1'b0;
`endif

    el_rx_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (data_o),
        .full  (full),
        .empty (empty)
    );

    assign valid_o = !empty;

endmodule
